// File: rtl/seq_calculator_if.sv
// seq_calculator_if: operand/opcode request and result handshake bundle for seq_calculator
interface seq_calculator_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0] op;
  logic in_valid;
  logic in_ready;
  logic [2*WIDTH-1:0] out;
  logic out_valid;
  logic out_ready;
  logic div_zero;
  modport master (output a, b, op, in_valid, out_ready, input in_ready, out, out_valid, div_zero);
  modport slave (input a, b, op, in_valid, out_ready, output in_ready, out, out_valid, div_zero);
endinterface

// File: rtl/seq_calculator.sv
// seq_calculator: handshaked WIDTH-bit calculator, single-cycle logic/add/sub, iterative mult/div
module seq_calculator #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  seq_calculator_if.slave bus
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r;
  logic is_mul, dz_r, accept, iter, last, ge, dz;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] w, w_mul, w_div, single, out_r;
  logic [W:0] sum, dif, acc, sh, trial;
  assign accept = state == IDLE && bus.in_valid;
  assign dz = bus.op == 3'b111 && bus.b == '0;
  assign iter = bus.op[2:1] == 2'b11 && !dz;
  assign last = cnt == CW'(W-1);
  assign sum = {1'b0, bus.a} + {1'b0, bus.b};
  assign dif = {1'b0, bus.a} - {1'b0, bus.b};
  assign single = bus.op == 3'b000 ? {{W{1'b0}}, bus.a & bus.b} :
                  bus.op == 3'b001 ? {{W{1'b0}}, bus.a | bus.b} :
                  bus.op == 3'b010 ? {{W{1'b1}}, ~bus.a} :
                  bus.op == 3'b011 ? {{W{1'b0}}, bus.a ^ bus.b} :
                  bus.op == 3'b100 ? {{(W-1){1'b0}}, sum} :
                  bus.op == 3'b101 ? {{(W-1){1'b0}}, dif} :
                  {bus.a, {W{1'b1}}};
  // shift-add: low half holds the unconsumed multiplier bits, high half the partial sum
  assign acc = {1'b0, w[2*W-1:W]} + (w[0] ? {1'b0, a_r} : '0);
  assign w_mul = {acc, w[W-1:1]};
  // restoring divide: high half is the running remainder, low half shifts dividend out and quotient in
  assign sh = {w[2*W-1:W], w[W-1]};
  assign trial = sh - {1'b0, b_r};
  assign ge = !trial[W];
  assign w_div = {ge ? trial[W-1:0] : sh[W-1:0], w[W-2:0], ge};
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.in_valid ? (iter ? BUSY : DONE) : IDLE) :
              state == BUSY ? (last ? DONE : BUSY) :
              (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      is_mul <= 1'b0;
      cnt <= '0;
      w <= '0;
      out_r <= '0;
      dz_r <= 1'b0;
    end else if (accept) begin
      a_r <= bus.a;
      b_r <= bus.b;
      is_mul <= !bus.op[0];
      cnt <= '0;
      w <= {{W{1'b0}}, bus.op[0] ? bus.a : bus.b};
      if (!iter) begin
        out_r <= single;
        dz_r <= dz;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      w <= is_mul ? w_mul : w_div;
      if (last) begin
        out_r <= is_mul ? w_mul : w_div;
        dz_r <= 1'b0;
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out = out_r;
  assign bus.div_zero = dz_r;
endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: directed vectors with a queue scoreboard checked by an independent monitor
module tb_seq_calculator;
  localparam logic [2:0] AND = 3'b000, OR = 3'b001, NOT = 3'b010, XOR = 3'b011;
  localparam logic [2:0] ADD = 3'b100, SUB = 3'b101, MUL = 3'b110, DIV = 3'b111;
  typedef struct {logic [15:0] out; logic dz;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t e;
  seq_calculator_if #(.WIDTH(8)) bus();
  seq_calculator #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0h expected none", bus.out);
      end else begin
        e = q.pop_front();
        chk("out", 32'(bus.out), 32'(e.out));
        chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
      end
    end
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                     input logic [15:0] exp, input logic dz, input int lat, input int hold, input bit poke);
    int n;
    @(posedge clk); #1;
    bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
    q.push_back('{exp, dz});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (poke && n >= 2 && n <= 4) begin
        chk("in_ready_busy", 32'(bus.in_ready), 0);
        bus.a = 8'd1; bus.b = 8'd1; bus.op = ADD; bus.in_valid = 1'b1;
      end
      if (poke && n == 5) bus.in_valid = 1'b0;
    end while (!bus.out_valid && n < 40);
    bus.in_valid = 1'b0;
    chk("latency", n, lat);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_out", 32'(bus.out), 32'(exp));
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk("valid_drop", 32'(bus.out_valid), 0);
    chk("in_ready_after", 32'(bus.in_ready), 1);
  endtask
  initial begin
    bus.a = '0; bus.b = '0; bus.op = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_div_zero", 32'(bus.div_zero), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(8'd200, 8'd100, ADD, 16'h012C, 1'b0, 1, 0, 1'b0);
    run(8'd5, 8'd9, SUB, 16'h01FC, 1'b0, 1, 0, 1'b0);
    run(8'd9, 8'd5, SUB, 16'h0004, 1'b0, 1, 0, 1'b0);
    run(8'h0F, 8'h33, NOT, 16'hFFF0, 1'b0, 1, 0, 1'b0);
    run(8'hCA, 8'h5F, AND, 16'h004A, 1'b0, 1, 0, 1'b0);
    run(8'hCA, 8'h5F, OR, 16'h00DF, 1'b0, 1, 0, 1'b0);
    run(8'hCA, 8'h5F, XOR, 16'h0095, 1'b0, 1, 0, 1'b0);
    run(8'd255, 8'd255, ADD, 16'h01FE, 1'b0, 1, 0, 1'b0);
    run(8'd255, 8'd255, MUL, 16'hFE01, 1'b0, 9, 0, 1'b1);
    run(8'd200, 8'd7, DIV, 16'h041C, 1'b0, 9, 0, 1'b0);
    run(8'd7, 8'd200, DIV, 16'h0700, 1'b0, 9, 0, 1'b0);
    run(8'd255, 8'd255, DIV, 16'h0001, 1'b0, 9, 0, 1'b0);
    run(8'd12, 8'd13, MUL, 16'h009C, 1'b0, 9, 5, 1'b0);
    run(8'd13, 8'd0, DIV, 16'h0DFF, 1'b1, 1, 0, 1'b0);
    @(posedge clk); #1;
    bus.a = 8'd200; bus.b = 8'd7; bus.op = DIV; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_out", 32'(bus.out), 0);
    chk("abort_div_zero", 32'(bus.div_zero), 0);
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(bus.out_valid), 0);
    end
    run(8'd1, 8'd1, ADD, 16'h0002, 1'b0, 1, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/seq_calculator.md
# seq_calculator

Parametrised, handshaked successor to the team's combinational 4-bit calculator. It executes one `a OP b` operation at a time on WIDTH-bit unsigned operands, using the same 3-bit opcode map. Logic, add and subtract complete in one cycle. Multiply (shift-add) and divide (restoring) are iterative, one bit per cycle. It sits between the operand/opcode front end and the display/result path, using valid/ready on both sides.

## Interface
- `WIDTH`, default 8: operand width. Must be ≥ 2.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `a` input WIDTH: operand A, unsigned.
- `b` input WIDTH: operand B, unsigned.
- `op` input 3: opcode. AND=000, OR=001, NOT=010, XOR=011, ADD=100, SUB=101, MULT=110, DIV=111.
- `in_valid` input 1: `a`/`b`/`op` are valid.
- `in_ready` output 1: block can accept an operation. High only in IDLE.
- `out` output 2*WIDTH: result, format per op below.
- `out_valid` output 1: `out` and `div_zero` are valid.
- `out_ready` input 1: consumer takes the result.
- `div_zero` output 1: the current result is a divide by zero.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, capture `a`, `b`, `op`. Go to DONE for single-cycle ops and divide-by-zero; otherwise go to BUSY with iteration counter = 0.
  - BUSY: one iteration per cycle. When the counter reaches WIDTH-1, load the result and go to DONE.
  - DONE: `out_valid`=1, `out`/`div_zero` held stable. When `out_ready`=1, go to IDLE.
- Operands are registered on accept; input changes after accept have no effect.
- `in_valid` is ignored outside IDLE. There is no queueing.
- Result formats (Z = zeros, O = ones, widths implied):
  - AND/OR/XOR: {Z, a op b}.
  - NOT: {O, ~a}. Upper half all ones, same as the legacy block.
  - ADD: {Z[WIDTH-1], carry, a+b}.
  - SUB: {Z[WIDTH-1], borrow, (a-b) mod 2^WIDTH}. borrow=1 iff a<b. This is new behaviour.
  - MULT: full 2*WIDTH-bit product a*b.
  - DIV (b≠0): {remainder, quotient}. Remainder occupies `out[2W-1:W]`, quotient occupies `out[W-1:0]`.
  - DIV (b=0): {a, all ones}, `div_zero`=1. Single cycle, no iteration.
- `div_zero` is 0 for every other case.
- Reset values: `out`=0, `out_valid`=0, `div_zero`=0, state IDLE, so `in_ready`=1 during and after reset.
- Reset asserted in BUSY or DONE aborts the operation. No `out_valid` is produced for it.

## Timing
- Accept edge = cycle k (`in_valid` & `in_ready` sampled high).
- Single-cycle ops and DIV-by-zero: `out_valid`=1 from cycle k+1.
- MULT and DIV: `out_valid`=1 from cycle k+1+WIDTH, i.e. exactly WIDTH cycles in BUSY.
- `out_valid` stays high until the edge where `out_ready`=1. It is 0 the following cycle, and `in_ready`=1 that same cycle.
- `out_ready` high in the cycle `out_valid` first rises: the result is consumed at that edge. Minimum throughput is one op per latency+1 cycles.
- `in_ready` is a combinational decode of state. It is never high while `out_valid` is high.
- `out_ready` is don't-care outside DONE.

## Test plan
- ADD, WIDTH=8: a=200, b=100, `out_ready`=1 → `out`=0x012C, `div_zero`=0, `out_valid` at k+1 for exactly one cycle.
- SUB: a=5, b=9 → `out`=0x01FC (borrow=1, diff=0xFC). NOT: a=0x0F → `out`=0xFFF0.
- MULT: a=255, b=255 → `out`=0xFE01, `out_valid` rises at k+9. `in_ready` stays 0 and a second `in_valid` during BUSY is ignored.
- DIV: a=200, b=7 → `out`=0x041C (r=4, q=28) at k+9. Also a=13, b=0 → `out`=0x0DFF, `div_zero`=1 at k+1.
- Backpressure: MULT 12*13 with `out_ready` low for 5 cycles → `out`=0x009C and `out_valid` held stable throughout, `in_ready`=0. Release → IDLE next cycle.
- Reset mid-op: assert `rst` asynchronously at cycle k+4 of a DIV → outputs zero immediately, `in_ready`=1, no `out_valid`. A following ADD 1+1 → `out`=0x0002.
